int_priority_ctrl: RTL and testbench
====================================

// Module: int_priority_ctrl
// PURPOSE
//  Prioritised, nestable interrupt controller between the board interrupt buttons and MIPS_CPU.
//  Detects rising edges on external requests and latches them as pending. Applies mask and global enable.
//  Offers one vectored request at a time with a req/ack handshake; CPU acks at an instruction boundary.
//  Tracks in-service levels until eret; drives inter_running LEDs. Runs on the divided CPU clock (clk_N net).
// PARAMETERS
//  NUM_SRC      3             number of interrupt sources; index NUM_SRC-1 has the highest priority
//  SYNC_STAGES  2             synchroniser flops per irq_in bit (>=2)
//  VEC_BASE     32'h0000_0200 handler address of source 0
//  VEC_STRIDE   32'h0000_0040 byte distance between consecutive handler vectors
// PORTS
//  clk           in   1        CPU clock; all state on posedge
//  clr_n         in   1        asynchronous, active-low reset
//  irq_in        in   NUM_SRC  raw asynchronous interrupt inputs; rising edge = request
//  ie            in   1        CPU global interrupt enable
//  mask_we       in   1        write strobe for mask register
//  mask_wdata    in   NUM_SRC  new mask; 1 = source enabled
//  mask_q        out  NUM_SRC  current mask
//  pending_q     out  NUM_SRC  latched, not yet granted requests
//  irq_req       out  1        request to CPU; held until irq_ack or withdrawal
//  irq_id        out  clog2(NUM_SRC)  granted source index; stable while irq_req=1
//  irq_vec       out  32       VEC_BASE + irq_id*VEC_STRIDE; stable while irq_req=1
//  irq_ack       in   1        CPU takes the interrupt; one-cycle pulse, valid only while irq_req=1
//  eret          in   1        CPU returns from the current handler; one-cycle pulse
//  inter_running out  NUM_SRC  in-service bit vector; several bits may be set when nested
//  spurious_eret out  1        one-cycle pulse: eret received while inter_running==0
// BEHAVIOUR
//  Reset (clr_n=0, asynchronous): mask_q all 1, pending_q, inter_running, irq_req, irq_id and irq_vec all 0.
//    Reset also clears the synchroniser and edge-detect flops, and puts the FSM in IDLE.
//  Edge capture:
//    Rising edge on irq_in[i] sets pending[i] exactly SYNC_STAGES+1 clk edges after the input rises.
//    Level-held inputs produce one request only.
//    A new edge in the same cycle as the ack of the same source leaves pending[i]=1; the set wins over the clear.
//  Priority level: run_lvl = index of the highest set inter_running bit, or -1 when none is set.
//  Eligible set: pending & mask_q, restricted to indices > run_lvl, and gated by ie.
//    The winner is the highest eligible index.
//  FSM IDLE:
//    If the eligible set is non-empty, latch winner into irq_id and irq_vec; next cycle irq_req=1, go to REQ.
//    Latency: pending set at cycle N gives irq_req at cycle N+1.
//  FSM REQ:
//    irq_id is frozen; a higher source arriving meanwhile waits for re-arbitration after the ack.
//    Ack: clear pending[id], set inter_running[id], drop irq_req next cycle, go to IDLE.
//    Withdrawal: if ie=0 or mask_q[id]=0 without ack, drop irq_req next cycle and go to IDLE; pending[id] is kept.
//    If ack and withdrawal occur in the same cycle, the ack wins.
//  eret:
//    Clears the highest set inter_running bit.
//    If no bit is set, nothing changes and spurious_eret pulses.
//  eret and irq_ack in the same cycle: apply eret first, then ack; both take effect in that cycle.
//  irq_ack while irq_req=0 is ignored.
//  mask_we takes effect next cycle. Masked sources keep accumulating pending bits.
//  Already-in-service sources are never re-granted until their eret.
// CONFIGURATION
//  INT_NEST_EN defined:
//    Nesting enabled; a higher-priority source preempts a running handler.
//  INT_NEST_EN undefined:
//    The eligible set is empty whenever inter_running!=0, so at most one bit of inter_running is ever set.
//    eret simply clears inter_running.
// STRUCTURE
//  Package mips_int_pkg: NUM_SRC, ID_W=clog2(NUM_SRC), VEC_BASE, VEC_STRIDE, and the FSM state enum {IDLE, REQ}.
//  Sub-module irq_edge_sync: one per source; holds the SYNC_STAGES synchroniser plus the edge-detect flop.
//    Output is a one-cycle rise pulse.
//  Top level: pending register, mask register, priority encoder, in-service vector, FSM.
// TESTING
//  T1 Reset and single request:
//    Pulse clr_n low, pulse irq_in[0]; with ie=1, pending_q=3'b001 at edge 3.
//    irq_req=1, irq_id=0, irq_vec=32'h200 at edge 4. Ack sets inter_running=3'b001. eret clears it.
//  T2 Simultaneous requests:
//    irq_in=3'b111 at once. Grants come out as id 2, then 1, then 0, one after each eret.
//    irq_vec values are 32'h280, 32'h240, 32'h200.
//  T3 Nesting with INT_NEST_EN defined:
//    Source 0 is in service and source 2 rises. Source 2 is granted and inter_running=3'b101.
//    eret gives 3'b001. Without the macro, source 2 waits until inter_running=0.
//  T4 Mask and ie withdrawal:
//    Set mask_wdata=3'b011 and raise irq_in[2]: no irq_req, pending_q=3'b100. Unmasking then grants source 2.
//    Dropping ie while in REQ drops irq_req next cycle and pending stays set.
//  T5 Same-cycle events:
//    eret and ack together on nested 3'b011 with id=2 give inter_running=3'b101.
//    A new edge on the acked source leaves pending set.
//  T6 Spurious eret and async reset:
//    eret with inter_running=0 gives a one-cycle spurious_eret pulse.
//    clr_n low mid-REQ immediately zeroes irq_req, pending_q and inter_running.

Source files
------------

// File: rtl/mips_int_pkg.sv
// mips_int_pkg: shared sizes, vector map, FSM states and priority helpers for int_priority_ctrl
package mips_int_pkg;
  localparam int NUM_SRC = 3;
  localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [31:0] VEC_BASE = 32'h0000_0200;
  localparam logic [31:0] VEC_STRIDE = 32'h0000_0040;

  typedef enum logic {IDLE, REQ} state_t;

  // Index of the highest set bit; 0 when the vector is empty
  function automatic logic [ID_W-1:0] hi_idx(input logic [NUM_SRC-1:0] v);
    logic [ID_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_SRC; i++) if (v[i]) r = ID_W'(i);
    return r;
  endfunction

  function automatic logic [31:0] vec_of(input logic [ID_W-1:0] id);
    return VEC_BASE + 32'(id) * VEC_STRIDE;
  endfunction
endpackage

// File: rtl/int_priority_ctrl_if.sv
// int_priority_ctrl_if: CPU-side request/ack, mask and status bundle of the interrupt controller
interface int_priority_ctrl_if;
  import mips_int_pkg::*;
  logic [NUM_SRC-1:0] irq_in;
  logic               ie;
  logic               mask_we;
  logic [NUM_SRC-1:0] mask_wdata;
  logic [NUM_SRC-1:0] mask_q;
  logic [NUM_SRC-1:0] pending_q;
  logic               irq_req;
  logic [ID_W-1:0]    irq_id;
  logic [31:0]        irq_vec;
  logic               irq_ack;
  logic               eret;
  logic [NUM_SRC-1:0] inter_running;
  logic               spurious_eret;

  modport master (
    output irq_in, ie, mask_we, mask_wdata, irq_ack, eret,
    input  mask_q, pending_q, irq_req, irq_id, irq_vec, inter_running, spurious_eret
  );

  modport slave (
    input  irq_in, ie, mask_we, mask_wdata, irq_ack, eret,
    output mask_q, pending_q, irq_req, irq_id, irq_vec, inter_running, spurious_eret
  );
endinterface

// File: rtl/irq_edge_sync.sv
// irq_edge_sync: multi-flop synchroniser plus edge detector giving a one-cycle rise pulse
module irq_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic clr_n,
  input  logic i_irq,
  output logic o_rise
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Shift the raw input through the synchroniser and remember the last synchronised level
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_irq};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;
endmodule

// File: rtl/int_priority_ctrl.sv
// int_priority_ctrl: prioritised vectored interrupt controller; INT_NEST_EN enables preemptive nesting
module int_priority_ctrl import mips_int_pkg::*; #(
  parameter int SYNC_STAGES = 2
) (
  input logic          clk,
  input logic          clr_n,
  int_priority_ctrl_if.slave bus
);
  state_t             r_state, w_next_state;
  logic [NUM_SRC-1:0] r_mask, r_pending, r_ir;
  logic [NUM_SRC-1:0] w_rise, w_elig, w_ack_oh, w_ir_eret;
  logic [ID_W-1:0]    r_id, w_win;
  logic [31:0]        r_vec;
  logic               r_spur, w_req, w_load, w_ack, w_withdraw;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
    irq_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .clr_n  (clr_n),
      .i_irq  (bus.irq_in[g]),
      .o_rise (w_rise[g])
    );
  end

`ifdef INT_NEST_EN
  logic [NUM_SRC-1:0] w_above;

  // A source may preempt only if no in-service bit sits at or above its index
  always_comb begin
    w_above = '0;
    for (int i = 0; i < NUM_SRC; i++) w_above[i] = (r_ir >> i) == '0;
  end

  assign w_elig    = bus.ie ? (r_pending & r_mask & w_above) : '0;
  assign w_ir_eret = bus.eret ? (r_ir & ~(NUM_SRC'(1) << hi_idx(r_ir))) : r_ir;
`else
  assign w_elig    = (bus.ie && r_ir == '0) ? (r_pending & r_mask) : '0;
  assign w_ir_eret = bus.eret ? '0 : r_ir;
`endif

  assign w_win      = hi_idx(w_elig);
  assign w_ack      = w_req & bus.irq_ack;
  assign w_withdraw = ~bus.ie | ~r_mask[r_id];
  assign w_ack_oh   = w_ack ? (NUM_SRC'(1) << r_id) : '0;

  // FSM state register
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) r_state <= IDLE;
    else r_state <= w_next_state;
  end

  // FSM next state: arbitrate in IDLE, hold the frozen grant in REQ until ack or withdrawal
  always_comb begin
    w_next_state = (r_state == IDLE) ? ((w_elig != '0) ? REQ : IDLE)
                                     : ((w_ack | w_withdraw) ? IDLE : REQ);
  end

  // FSM outputs: request level and grant-latch strobe
  always_comb begin
    w_req  = r_state == REQ;
    w_load = (r_state == IDLE) && (w_elig != '0);
  end

  // Mask, pending, in-service, grant and spurious-eret registers; new edges win over the ack clear
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_mask    <= '1;
      r_pending <= '0;
      r_ir      <= '0;
      r_id      <= '0;
      r_vec     <= '0;
      r_spur    <= 1'b0;
    end else begin
      if (bus.mask_we) r_mask <= bus.mask_wdata;
      r_pending <= (r_pending & ~w_ack_oh) | w_rise;
      r_ir      <= w_ir_eret | w_ack_oh;
      r_spur    <= bus.eret & (r_ir == '0);
      if (w_load) begin
        r_id  <= w_win;
        r_vec <= vec_of(w_win);
      end
    end
  end

  assign bus.mask_q        = r_mask;
  assign bus.pending_q     = r_pending;
  assign bus.irq_req       = w_req;
  assign bus.irq_id        = r_id;
  assign bus.irq_vec       = r_vec;
  assign bus.inter_running = r_ir;
  assign bus.spurious_eret = r_spur;
endmodule

// File: tb/tb_int_priority_ctrl.sv
// tb_int_priority_ctrl: table-driven and sequence checks of int_priority_ctrl
module tb_int_priority_ctrl;
  logic clk = 1'b0;
  logic clr_n;
  int   checks = 0;
  int   errors = 0;

  int_priority_ctrl_if bus();

  int_priority_ctrl #(.SYNC_STAGES(2)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  irq;
    logic [2:0]  mask;
    logic        ie;
    logic [2:0]  pend;
    logic        req;
    logic [1:0]  id;
    logic [31:0] vec;
  } vec_t;

  vec_t tbl[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr_n = 1'b0;
    bus.irq_in = '0;
    bus.ie = 1'b0;
    bus.mask_we = 1'b0;
    bus.mask_wdata = '0;
    bus.irq_ack = 1'b0;
    bus.eret = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    tick();
  endtask

  task automatic write_mask(input logic [2:0] m);
    bus.mask_wdata = m;
    bus.mask_we = 1'b1;
    tick();
    bus.mask_we = 1'b0;
  endtask

  task automatic pulse_ack();
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
  endtask

  task automatic pulse_eret();
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
  endtask

  task automatic raise(input logic [2:0] p);
    bus.irq_in = p;
    repeat (4) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clr_n = 1'b0;
    tbl[0] = '{3'b001, 3'b111, 1'b1, 3'b001, 1'b1, 2'd0, 32'h200};
    tbl[1] = '{3'b010, 3'b111, 1'b1, 3'b010, 1'b1, 2'd1, 32'h240};
    tbl[2] = '{3'b100, 3'b111, 1'b1, 3'b100, 1'b1, 2'd2, 32'h280};
    tbl[3] = '{3'b111, 3'b111, 1'b1, 3'b111, 1'b1, 2'd2, 32'h280};
    tbl[4] = '{3'b011, 3'b111, 1'b1, 3'b011, 1'b1, 2'd1, 32'h240};
    tbl[5] = '{3'b100, 3'b011, 1'b1, 3'b100, 1'b0, 2'd0, 32'h000};
    tbl[6] = '{3'b101, 3'b001, 1'b1, 3'b101, 1'b1, 2'd0, 32'h200};
    tbl[7] = '{3'b000, 3'b111, 1'b1, 3'b000, 1'b0, 2'd0, 32'h000};
    tbl[8] = '{3'b010, 3'b111, 1'b0, 3'b010, 1'b0, 2'd0, 32'h000};

    do_reset();
    chk("rst mask", 32'(bus.mask_q), 32'h7);
    chk("rst pend", 32'(bus.pending_q), 32'h0);
    chk("rst req", 32'(bus.irq_req), 32'h0);
    chk("rst id", 32'(bus.irq_id), 32'h0);
    chk("rst vec", bus.irq_vec, 32'h0);
    chk("rst run", 32'(bus.inter_running), 32'h0);
    chk("rst spur", 32'(bus.spurious_eret), 32'h0);

    for (int k = 0; k < 9; k++) begin
      do_reset();
      bus.ie = tbl[k].ie;
      write_mask(tbl[k].mask);
      bus.irq_in = tbl[k].irq;
      repeat (2) tick();
      chk($sformatf("v%0d pend@2", k), 32'(bus.pending_q), 32'h0);
      tick();
      chk($sformatf("v%0d pend@3", k), 32'(bus.pending_q), 32'(tbl[k].pend));
      chk($sformatf("v%0d req@3", k), 32'(bus.irq_req), 32'h0);
      tick();
      chk($sformatf("v%0d req@4", k), 32'(bus.irq_req), 32'(tbl[k].req));
      chk($sformatf("v%0d id", k), 32'(bus.irq_id), 32'(tbl[k].id));
      chk($sformatf("v%0d vec", k), bus.irq_vec, tbl[k].vec);
      chk($sformatf("v%0d pend@4", k), 32'(bus.pending_q), 32'(tbl[k].pend));
    end

    do_reset();
    bus.ie = 1'b1;
    raise(3'b001);
    chk("t1 req", 32'(bus.irq_req), 32'h1);
    pulse_ack();
    chk("t1 run ack", 32'(bus.inter_running), 32'h1);
    chk("t1 req drop", 32'(bus.irq_req), 32'h0);
    chk("t1 pend clr", 32'(bus.pending_q), 32'h0);
    pulse_eret();
    chk("t1 run eret", 32'(bus.inter_running), 32'h0);
    chk("t1 no spur", 32'(bus.spurious_eret), 32'h0);
    repeat (4) tick();
    chk("t1 level once", 32'(bus.pending_q), 32'h0);
    chk("t1 level noreq", 32'(bus.irq_req), 32'h0);

    do_reset();
    bus.ie = 1'b1;
    raise(3'b111);
    chk("t2 id2", 32'(bus.irq_id), 32'h2);
    chk("t2 vec2", bus.irq_vec, 32'h280);
    pulse_ack();
    chk("t2 run2", 32'(bus.inter_running), 32'h4);
    chk("t2 pend", 32'(bus.pending_q), 32'h3);
    tick();
    chk("t2 blocked", 32'(bus.irq_req), 32'h0);
    pulse_eret();
    tick();
    chk("t2 req1", 32'(bus.irq_req), 32'h1);
    chk("t2 id1", 32'(bus.irq_id), 32'h1);
    chk("t2 vec1", bus.irq_vec, 32'h240);
    pulse_ack();
    pulse_eret();
    tick();
    chk("t2 id0", 32'(bus.irq_id), 32'h0);
    chk("t2 vec0", bus.irq_vec, 32'h200);
    pulse_ack();
    pulse_eret();
    chk("t2 run end", 32'(bus.inter_running), 32'h0);
    chk("t2 pend end", 32'(bus.pending_q), 32'h0);

    do_reset();
    bus.ie = 1'b1;
    raise(3'b001);
    pulse_ack();
    raise(3'b100);
`ifdef INT_NEST_EN
    chk("t3 preempt req", 32'(bus.irq_req), 32'h1);
    chk("t3 preempt id", 32'(bus.irq_id), 32'h2);
    pulse_ack();
    chk("t3 nested run", 32'(bus.inter_running), 32'h5);
    pulse_eret();
    chk("t3 eret run", 32'(bus.inter_running), 32'h1);
`else
    chk("t3 wait req", 32'(bus.irq_req), 32'h0);
    chk("t3 wait pend", 32'(bus.pending_q), 32'h4);
    pulse_eret();
    chk("t3 eret run", 32'(bus.inter_running), 32'h0);
    tick();
    chk("t3 late req", 32'(bus.irq_req), 32'h1);
    chk("t3 late id", 32'(bus.irq_id), 32'h2);
    pulse_ack();
    chk("t3 run2", 32'(bus.inter_running), 32'h4);
`endif
    chk("t3 pend", 32'(bus.pending_q), 32'h0);

    do_reset();
    bus.ie = 1'b1;
    write_mask(3'b011);
    chk("t4 mask", 32'(bus.mask_q), 32'h3);
    raise(3'b100);
    tick();
    chk("t4 masked req", 32'(bus.irq_req), 32'h0);
    chk("t4 masked pend", 32'(bus.pending_q), 32'h4);
    write_mask(3'b111);
    tick();
    chk("t4 unmask req", 32'(bus.irq_req), 32'h1);
    chk("t4 unmask id", 32'(bus.irq_id), 32'h2);
    bus.ie = 1'b0;
    tick();
    chk("t4 ie drop req", 32'(bus.irq_req), 32'h0);
    chk("t4 ie drop pend", 32'(bus.pending_q), 32'h4);
    bus.ie = 1'b1;
    tick();
    chk("t4 regrant", 32'(bus.irq_req), 32'h1);
    write_mask(3'b011);
    chk("t4 mask delay", 32'(bus.irq_req), 32'h1);
    tick();
    chk("t4 mask withdraw", 32'(bus.irq_req), 32'h0);
    chk("t4 mask pend", 32'(bus.pending_q), 32'h4);
    write_mask(3'b111);
    tick();
    bus.ie = 1'b0;
    pulse_ack();
    bus.ie = 1'b1;
    chk("t4 ack wins run", 32'(bus.inter_running), 32'h4);
    chk("t4 ack wins pend", 32'(bus.pending_q), 32'h0);

    do_reset();
    bus.ie = 1'b1;
    bus.irq_in = 3'b001;
    tick();
    bus.irq_in = 3'b000;
    tick();
    bus.irq_in = 3'b001;
    tick();
    chk("t5 pend", 32'(bus.pending_q), 32'h1);
    tick();
    chk("t5 req", 32'(bus.irq_req), 32'h1);
    pulse_ack();
    chk("t5 set wins", 32'(bus.pending_q), 32'h1);
    chk("t5 run", 32'(bus.inter_running), 32'h1);
    bus.irq_in = 3'b000;
    pulse_eret();
    tick();
    chk("t5 regrant", 32'(bus.irq_req), 32'h1);
    bus.eret = 1'b1;
    pulse_ack();
    bus.eret = 1'b0;
    chk("t5 eret+ack run", 32'(bus.inter_running), 32'h1);
    chk("t5 eret+ack spur", 32'(bus.spurious_eret), 32'h1);
    tick();
    chk("t5 spur pulse", 32'(bus.spurious_eret), 32'h0);
`ifdef INT_NEST_EN
    do_reset();
    bus.ie = 1'b1;
    raise(3'b001);
    pulse_ack();
    raise(3'b010);
    pulse_ack();
    chk("t5 nest 011", 32'(bus.inter_running), 32'h3);
    raise(3'b100);
    chk("t5 nest id2", 32'(bus.irq_id), 32'h2);
    bus.eret = 1'b1;
    pulse_ack();
    bus.eret = 1'b0;
    chk("t5 nest 101", 32'(bus.inter_running), 32'h5);
`endif

    do_reset();
    pulse_eret();
    chk("t6 spur", 32'(bus.spurious_eret), 32'h1);
    chk("t6 spur run", 32'(bus.inter_running), 32'h0);
    tick();
    chk("t6 spur end", 32'(bus.spurious_eret), 32'h0);
    bus.ie = 1'b1;
    raise(3'b011);
    pulse_ack();
    chk("t6 run", 32'(bus.inter_running), 32'h2);
    raise(3'b100);
`ifdef INT_NEST_EN
    chk("t6 pre req", 32'(bus.irq_req), 32'h1);
`endif
    clr_n = 1'b0;
    #2;
    chk("t6 async req", 32'(bus.irq_req), 32'h0);
    chk("t6 async pend", 32'(bus.pending_q), 32'h0);
    chk("t6 async run", 32'(bus.inter_running), 32'h0);
    chk("t6 async vec", bus.irq_vec, 32'h0);
    chk("t6 async mask", 32'(bus.mask_q), 32'h7);
    bus.irq_in = '0;
    @(negedge clk);
    clr_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
